// File: rtl/apb_requester_mux.sv
// Front-handshake to APB requester: address decode, SETUP/ACCESS with wait states, read mux.
// Zero-wait latency 3 cycles (+1 per PREADY-low); optional APB_TIMEOUT_EN aborts long waits.
module apb_requester_mux #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_COMP   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000_0000,
  parameter int                    SLOT_BITS  = 12,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           transfer,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           ready,
  output logic                           error,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [NUM_COMP-1:0]            PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [NUM_COMP-1:0]            PREADY,
  input  logic [NUM_COMP*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_COMP-1:0]            PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                  state, state_d;
  logic [NUM_COMP-1:0]     psel_d;
  logic                    penable_d, pwrite_d, ready_d, error_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;

  logic [ADDR_WIDTH-1:0]   offset, slot;
  logic                    hit;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // Out-of-window addresses wrap in the subtraction, so the lower bound is checked separately.
  assign offset = addr - BASE_ADDR;
  assign slot   = offset >> SLOT_BITS;
  assign hit    = (addr >= BASE_ADDR) && (slot < ADDR_WIDTH'(NUM_COMP));

  // PSEL is one-hot and held through ACCESS, so it doubles as the return-path select.
  assign sel_ready = |(PREADY & PSEL);
  assign sel_err   = |(PSLVERR & PSEL);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wait_cnt, wait_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d   = state;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    rdata_d   = rdata;
    error_d   = error;
    ready_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          if (hit) begin
            psel_d  = NUM_COMP'(1) << slot;
            state_d = SETUP;
          end else begin
            error_d = 1'b1;
            rdata_d = '0;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          error_d   = sel_err;
          rdata_d   = (!PWRITE && !sel_err) ? sel_rdata : '0;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          error_d   = 1'b1;
          rdata_d   = '0;
          ready_d   = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        error_d = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      error   <= error_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= '0;
    else       wait_cnt <= wait_cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb_requester_mux.sv
// Directed bench for apb_requester_mux: writes, wait states, decode/slave errors, reset, timeout.
module tb_apb_requester_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic         transfer, write;
  logic [31:0]  addr, wdata, rdata;
  logic         ready, error;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [3:0]   PREADY, PSLVERR;
  logic [127:0] PRDATA;

  int checks = 0;
  int errors = 0;
  int rdy_seen;

  always #5 clk = ~clk;

  apb_requester_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_COMP(4),
    .BASE_ADDR(32'h1000_0000), .SLOT_BITS(12), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .error(error), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;

    step();
    check("rst_psel", PSEL, 4'b0000);
    check("rst_pen", PENABLE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    step();

    // Zero-wait write to completer 1
    req(1'b1, 32'h1000_1004, 32'hDEAD_BEEF);
    PREADY = 4'b0010;
    step();
    check("wr_psel_k1", PSEL, 4'b0010);
    check("wr_pen_k1", PENABLE, 1'b0);
    check("wr_paddr", PADDR, 32'h1000_1004);
    check("wr_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("wr_pwrite", PWRITE, 1'b1);
    check("wr_rdy_k1", ready, 1'b0);
    step();
    check("wr_pen_k2", PENABLE, 1'b1);
    check("wr_psel_k2", PSEL, 4'b0010);
    check("wr_rdy_k2", ready, 1'b0);
    step();
    check("wr_rdy_k3", ready, 1'b1);
    check("wr_err_k3", error, 1'b0);
    check("wr_psel_k3", PSEL, 4'b0000);
    check("wr_pen_k3", PENABLE, 1'b0);
    transfer = 1'b0;
    step();
    check("wr_rdy_pulse", ready, 1'b0);
    check("wr_paddr_hold", PADDR, 32'h1000_1004);

    // Read completer 3 with two wait states; unselected completers are noisy
    req(1'b0, 32'h1000_3000, 32'h0);
    PREADY  = 4'b0111;
    PSLVERR = 4'b0001;
    PRDATA  = {32'h1234_5678, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000};
    step();
    check("rd_psel", PSEL, 4'b1000);
    step();
    check("rd_pen", PENABLE, 1'b1);
    addr = 32'h1000_0000; wdata = 32'hFFFF_FFFF; write = 1'b1;
    for (int w = 0; w < 2; w++) begin
      step();
      check("rd_wait_rdy", ready, 1'b0);
      check("rd_wait_psel", PSEL, 4'b1000);
      check("rd_wait_pen", PENABLE, 1'b1);
      check("rd_wait_paddr", PADDR, 32'h1000_3000);
      check("rd_wait_pwrite", PWRITE, 1'b0);
    end
    PREADY = 4'b1000;
    step();
    check("rd_rdy", ready, 1'b1);
    check("rd_rdata", rdata, 32'h1234_5678);
    check("rd_err", error, 1'b0);
    transfer = 1'b0; PSLVERR = '0;
    step();

    // Decode errors: slot past NUM_COMP, then below the window
    req(1'b0, 32'h1000_4000, 32'h0);
    PREADY = 4'b1111;
    step();
    check("dec_hi_rdy", ready, 1'b1);
    check("dec_hi_err", error, 1'b1);
    check("dec_hi_rdata", rdata, 32'h0);
    check("dec_hi_psel", PSEL, 4'b0000);
    transfer = 1'b0;
    step();
    check("dec_hi_idle", ready, 1'b0);
    req(1'b0, 32'h0FFF_FFFC, 32'h0);
    step();
    check("dec_lo_rdy", ready, 1'b1);
    check("dec_lo_err", error, 1'b1);
    check("dec_lo_psel", PSEL, 4'b0000);
    transfer = 1'b0;
    step();

    // Slave error from completer 2, then a clean read from completer 0
    req(1'b0, 32'h1000_2010, 32'h0);
    PREADY  = 4'b0100;
    PSLVERR = 4'b0100;
    PRDATA  = {32'h0, 32'hAAAA_5555, 32'h0, 32'hCAFE_F00D};
    step();
    check("slv_psel", PSEL, 4'b0100);
    step(); step();
    check("slv_rdy", ready, 1'b1);
    check("slv_err", error, 1'b1);
    check("slv_rdata", rdata, 32'h0);
    transfer = 1'b0; PSLVERR = '0;
    step();
    req(1'b0, 32'h1000_0000, 32'h0);
    PREADY = 4'b0001;
    step(); step(); step();
    check("ok_rdy", ready, 1'b1);
    check("ok_err", error, 1'b0);
    check("ok_rdata", rdata, 32'hCAFE_F00D);
    transfer = 1'b0;
    step();

    // Reset while stalled in ACCESS
    req(1'b0, 32'h1000_1000, 32'h0);
    PREADY = 4'b0000;
    step(); step(); step();
    check("ar_pen_before", PENABLE, 1'b1);
    reset = 1'b1;
    #1;
    check("ar_psel", PSEL, 4'b0000);
    check("ar_pen", PENABLE, 1'b0);
    check("ar_paddr", PADDR, 32'h0);
    check("ar_rdy", ready, 1'b0);
    transfer = 1'b0;
    step();
    check("ar_rdy_hold", ready, 1'b0);
    reset = 1'b0;
    step();
    req(1'b1, 32'h1000_1000, 32'h1111_2222);
    PREADY = 4'b0010;
    step(); step(); step();
    check("ar_new_rdy", ready, 1'b1);
    check("ar_new_err", error, 1'b0);
    check("ar_new_pwdata", PWDATA, 32'h1111_2222);
    transfer = 1'b0;
    step();

    // Completer 3 never ready
    req(1'b0, 32'h1000_3000, 32'h0);
    PREADY = 4'b0000;
    step(); step();
    transfer = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int w = 0; w < 7; w++) begin
      step();
      check("to_wait_psel", PSEL, 4'b1000);
      check("to_wait_rdy", ready, 1'b0);
    end
    step();
    check("to_psel", PSEL, 4'b0000);
    check("to_rdy", ready, 1'b1);
    check("to_err", error, 1'b1);
    check("to_rdata", rdata, 32'h0);
    PREADY = 4'b1000;
    step();
    check("to_late_rdy", ready, 1'b0);
`else
    rdy_seen = 0;
    for (int w = 0; w < 20; w++) begin
      step();
      if (ready) rdy_seen++;
    end
    check("nto_no_rdy", rdy_seen, 0);
    check("nto_psel", PSEL, 4'b1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
